// File: rtl/conv_frame_loader.sv
// -----------------------------------------------------------------------------
// conv_frame_loader
//   Upstream stage of the 16-tap convolution block. Takes a serial stream of
//   DATA_W-bit samples over valid/ready. The first N_TAPS accepted samples go to
//   operand A and the next N_TAPS go to operand B. The packed frame is then held
//   stable, with frame_valid high, until the convolution side acknowledges it.
//   All-zero flags for each operand are built up while the samples arrive.
//
// Optional feature (macro CONV_LOADER_ZERO_DROP_EN):
//   When the macro is defined, a frame with an all-zero A or an all-zero B
//   operand is discarded instead of presented, and drop_cnt counts the discarded
//   frames. The default build, with the macro undefined, presents every frame.
//
// Ports:
//   clk, rst_n    clock; asynchronous active-low reset
//   in_data       incoming sample
//   in_valid      in_data is valid this cycle
//   in_ready      loader accepts a sample this cycle (registered)
//   flush         synchronous abort of the current frame
//   frame_ack     downstream has consumed the presented frame
//   signal_a/b    packed operands; sample k occupies bits [k*DATA_W +: DATA_W]
//   frame_valid   operands and zero flags are complete and stable
//   zero_a/b      every A or B sample of the presented frame is 0
//   drop_cnt      frames discarded as all-zero (macro builds only)
//   frame_cnt     frames acknowledged; wraps at 0xFFFF
// -----------------------------------------------------------------------------
module conv_frame_loader #(
    parameter int N_TAPS = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     frame_ack,
    output logic [N_TAPS*DATA_W-1:0] signal_a,
    output logic [N_TAPS*DATA_W-1:0] signal_b,
    output logic                     frame_valid,
    output logic                     zero_a,
    output logic                     zero_b,
`ifdef CONV_LOADER_ZERO_DROP_EN
    output logic [15:0]              drop_cnt,
`endif
    output logic [15:0]              frame_cnt
);

    localparam int CW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_TAPS - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

    state_t                          state_q;
    logic [CW-1:0]                   cnt_q;
    // Slot k of the 2-D packed array flattens to bits [k*DATA_W +: DATA_W].
    logic [N_TAPS-1:0][DATA_W-1:0]   signal_a_q, signal_b_q;
    logic                            in_ready_q, frame_valid_q;
    logic                            zero_a_q, zero_b_q;
    logic [15:0]                     frame_cnt_q;
`ifdef CONV_LOADER_ZERO_DROP_EN
    logic [15:0]                     drop_cnt_q;
`endif

    logic xfer, last, zero_a_d, zero_b_d;
    logic [CW-1:0] cnt_d;

    assign xfer     = in_valid && in_ready_q;
    assign last     = (cnt_q == LAST);
    assign cnt_d    = last ? '0 : cnt_q + 1'b1;
    // These flags include the sample being accepted on this edge, so the
    // decision to drop a frame already sees the final B sample.
    assign zero_a_d = zero_a_q && (in_data == '0);
    assign zero_b_d = zero_b_q && (in_data == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LOAD_A;
            cnt_q         <= '0;
            signal_a_q    <= '0;
            signal_b_q    <= '0;
            in_ready_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            zero_a_q      <= 1'b1;
            zero_b_q      <= 1'b1;
            frame_cnt_q   <= '0;
`ifdef CONV_LOADER_ZERO_DROP_EN
            drop_cnt_q    <= '0;
`endif
        end else if (flush) begin
            // A flush wins over a transfer or an ack on the same edge.
            // The operand data is left in place; only the control state restarts.
            state_q       <= LOAD_A;
            cnt_q         <= '0;
            in_ready_q    <= 1'b1;
            frame_valid_q <= 1'b0;
            zero_a_q      <= 1'b1;
            zero_b_q      <= 1'b1;
        end else begin
            case (state_q)
                LOAD_A: begin
                    in_ready_q <= 1'b1;
                    if (xfer) begin
                        signal_a_q[cnt_q] <= in_data;
                        zero_a_q          <= zero_a_d;
                        cnt_q             <= cnt_d;
                        if (last) state_q <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        signal_b_q[cnt_q] <= in_data;
                        zero_b_q          <= zero_b_d;
                        cnt_q             <= cnt_d;
                        if (last) begin
`ifdef CONV_LOADER_ZERO_DROP_EN
                            if (zero_a_q || zero_b_d) begin
                                // Discard the frame and start over; it is never presented.
                                drop_cnt_q <= drop_cnt_q + 16'd1;
                                state_q    <= LOAD_A;
                                zero_a_q   <= 1'b1;
                                zero_b_q   <= 1'b1;
                            end else begin
                                state_q       <= HOLD;
                                frame_valid_q <= 1'b1;
                                in_ready_q    <= 1'b0;
                            end
`else
                            state_q       <= HOLD;
                            frame_valid_q <= 1'b1;
                            in_ready_q    <= 1'b0;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (frame_ack) begin
                        state_q       <= LOAD_A;
                        cnt_q         <= '0;
                        in_ready_q    <= 1'b1;
                        frame_valid_q <= 1'b0;
                        zero_a_q      <= 1'b1;
                        zero_b_q      <= 1'b1;
                        frame_cnt_q   <= frame_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q    <= LOAD_A;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign signal_a    = signal_a_q;
    assign signal_b    = signal_b_q;
    assign frame_valid = frame_valid_q;
    assign zero_a      = zero_a_q;
    assign zero_b      = zero_b_q;
    assign frame_cnt   = frame_cnt_q;
`ifdef CONV_LOADER_ZERO_DROP_EN
    assign drop_cnt    = drop_cnt_q;
`endif

endmodule

// File: tb/tb_conv_frame_loader.sv
module tb_conv_frame_loader;

    localparam int N = 16;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           flush = 1'b0;
    logic           frame_ack = 1'b0;
    logic           in_ready, frame_valid, zero_a, zero_b;
    logic [N*W-1:0] signal_a, signal_b;
    logic [15:0]    frame_cnt;
`ifdef CONV_LOADER_ZERO_DROP_EN
    logic [15:0]    drop_cnt;
`endif

    conv_frame_loader #(.N_TAPS(N), .DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .frame_ack(frame_ack),
        .signal_a(signal_a), .signal_b(signal_b), .frame_valid(frame_valid),
        .zero_a(zero_a), .zero_b(zero_b),
`ifdef CONV_LOADER_ZERO_DROP_EN
        .drop_cnt(drop_cnt),
`endif
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int fcnt_exp = 0;
    logic [W-1:0] src[$];   // samples still to be offered
    logic [W-1:0] acc[$];   // reference model: accepted samples of the current frame

    // Expected operand: the 16 accepted samples starting at base, in acceptance order.
    function automatic logic [N*W-1:0] pack(input int base);
        logic [N*W-1:0] p;
        p = '0;
        for (int k = 0; k < N; k++) p[k*W +: W] = acc[base+k];
        return p;
    endfunction

    function automatic logic all_zero(input int base);
        for (int k = 0; k < N; k++) if (acc[base+k] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // Offers samples from src until n of them are accepted. Returns the cycle count,
    // the cycles where frame_valid was high before 32 samples were held, and a timeout flag.
    task automatic feed(input int n, input bit gaps, input bit ack_in,
                        output int cycles, output int early, output bit tmo);
        int got;
        logic hit;
        got = 0; cycles = 0; early = 0; tmo = 1'b0;
        while (got < n) begin
            if (cycles > 2000) begin tmo = 1'b1; break; end
            in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data   = (in_valid && src.size() > 0) ? src[0] : W'($urandom);
            frame_ack = ack_in;
            hit = in_valid && in_ready;
            cyc();
            cycles++;
            if (hit) begin acc.push_back(src.pop_front()); got++; end
            if (acc.size() < 2*N && frame_valid) early++;
        end
        in_valid = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic fill_random(input int n, input bit nonzero);
        for (int i = 0; i < n; i++) src.push_back(nonzero ? W'($urandom_range(1, 255)) : W'($urandom));
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if ({in_ready, frame_valid, zero_a, zero_b} !== 4'b0011) begin n_err++;
            $display("FAIL reset_ctrl: got rdy/fv/za/zb=%b expected 0011", {in_ready, frame_valid, zero_a, zero_b}); end
        n_cmp++; if ({signal_a, signal_b} !== '0) begin n_err++;
            $display("FAIL reset_operands: got %h %h expected 0", signal_a, signal_b); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_err++;
            $display("FAIL reset_fcnt: got %0d expected 0", frame_cnt); end
        @(posedge clk); #1; rst_n = 1'b1;
        cyc();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL ready_after_release: got %b expected 1", in_ready); end
    endtask

    task automatic test_stream();
        int cyc_n, early; bit tmo;
        acc.delete();
        for (int i = 1; i <= 2*N; i++) src.push_back(W'(i));
        feed(2*N, 1'b0, 1'b0, cyc_n, early, tmo);
        n_cmp++; if (tmo || cyc_n != 2*N || early != 0) begin n_err++;
            $display("FAIL stream_timing: got cycles=%0d early=%0d tmo=%0b expected 32/0/0", cyc_n, early, tmo); end
        n_cmp++; if (frame_valid !== 1'b1) begin n_err++;
            $display("FAIL stream_fv: got %b expected 1", frame_valid); end
        n_cmp++; if ({signal_a[7:0], signal_a[127:120], signal_b[7:0], signal_b[127:120]} !== 32'h01_10_11_20) begin n_err++;
            $display("FAIL stream_slots: got %h expected 01101120",
                     {signal_a[7:0], signal_a[127:120], signal_b[7:0], signal_b[127:120]}); end
        n_cmp++; if (signal_a !== pack(0) || signal_b !== pack(N)) begin n_err++;
            $display("FAIL stream_pack: got %h %h expected %h %h", signal_a, signal_b, pack(0), pack(N)); end
        n_cmp++; if ({zero_a, zero_b} !== 2'b00) begin n_err++;
            $display("FAIL stream_zero: got %b expected 00", {zero_a, zero_b}); end
    endtask

    task automatic test_hold_ack();
        logic [N*W-1:0] sa, sb;
        int bad;
        sa = signal_a; sb = signal_b; bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = W'($urandom); frame_ack = 1'b0;
            cyc();
            if (in_ready !== 1'b0 || frame_valid !== 1'b1 || signal_a !== sa || signal_b !== sb) bad++;
        end
        in_valid = 1'b0;
        n_cmp++; if (bad != 0) begin n_err++;
            $display("FAIL hold_stable: got %0d disturbed cycles expected 0", bad); end
        frame_ack = 1'b1; cyc(); frame_ack = 1'b0; fcnt_exp++;
        n_cmp++; if ({frame_valid, in_ready, zero_a, zero_b} !== 4'b0111) begin n_err++;
            $display("FAIL ack_ctrl: got fv/rdy/za/zb=%b expected 0111", {frame_valid, in_ready, zero_a, zero_b}); end
        n_cmp++; if (frame_cnt !== 16'(fcnt_exp)) begin n_err++;
            $display("FAIL ack_fcnt: got %0d expected %0d", frame_cnt, fcnt_exp); end
        n_cmp++; if (signal_a !== sa) begin n_err++;
            $display("FAIL ack_keeps_data: got %h expected %h", signal_a, sa); end
    endtask

    // Random gaps, with frame_ack held high during loading where it must be ignored.
    task automatic test_gaps();
        int cyc_n, early, stay; bit tmo;
        acc.delete();
        fill_random(2*N, 1'b0);
        feed(2*N, 1'b1, 1'b1, cyc_n, early, tmo);
        n_cmp++; if (tmo || early != 0 || frame_valid !== 1'b1) begin n_err++;
            $display("FAIL gaps_fv: got fv=%b early=%0d tmo=%0b expected 1/0/0", frame_valid, early, tmo); end
        n_cmp++; if (signal_a !== pack(0) || signal_b !== pack(N)) begin n_err++;
            $display("FAIL gaps_pack: got %h %h expected %h %h", signal_a, signal_b, pack(0), pack(N)); end
        n_cmp++; if ({zero_a, zero_b} !== {all_zero(0), all_zero(N)}) begin n_err++;
            $display("FAIL gaps_zero: got %b expected %b", {zero_a, zero_b}, {all_zero(0), all_zero(N)}); end
        n_cmp++; if (frame_cnt !== 16'(fcnt_exp)) begin n_err++;
            $display("FAIL ack_ignored_in_load: got %0d expected %0d", frame_cnt, fcnt_exp); end
        stay = 0;
        for (int i = 0; i < 3; i++) begin cyc(); if (frame_valid === 1'b1) stay++; end
        n_cmp++; if (stay != 3) begin n_err++;
            $display("FAIL gaps_fv_held: got %0d expected 3", stay); end
        frame_ack = 1'b1; cyc(); frame_ack = 1'b0; fcnt_exp++;
    endtask

    task automatic test_zero_frame();
        int cyc_n, early; bit tmo;
        acc.delete();
        for (int i = 0; i < N; i++) src.push_back(8'h00);
        for (int i = 0; i < N; i++) src.push_back(8'h05);
        feed(2*N, 1'b0, 1'b0, cyc_n, early, tmo);
`ifdef CONV_LOADER_ZERO_DROP_EN
        for (int i = 0; i < 3; i++) begin cyc(); if (frame_valid) early++; end
        n_cmp++; if (tmo || early != 0 || frame_valid !== 1'b0) begin n_err++;
            $display("FAIL drop_fv: got fv=%b early=%0d expected 0/0", frame_valid, early); end
        n_cmp++; if (drop_cnt !== 16'd1 || frame_cnt !== 16'(fcnt_exp)) begin n_err++;
            $display("FAIL drop_cnt: got drop=%0d fcnt=%0d expected 1/%0d", drop_cnt, frame_cnt, fcnt_exp); end
        acc.delete();
        fill_random(2*N, 1'b1);
        feed(2*N, 1'b0, 1'b0, cyc_n, early, tmo);
        n_cmp++; if (tmo || frame_valid !== 1'b1 || signal_a !== pack(0) || signal_b !== pack(N)) begin n_err++;
            $display("FAIL after_drop: got fv=%b %h %h expected 1 %h %h", frame_valid, signal_a, signal_b, pack(0), pack(N)); end
`else
        n_cmp++; if (tmo || frame_valid !== 1'b1 || {zero_a, zero_b} !== 2'b10) begin n_err++;
            $display("FAIL zero_frame: got fv=%b za/zb=%b expected 1 10", frame_valid, {zero_a, zero_b}); end
        n_cmp++; if (signal_a !== pack(0) || signal_b !== pack(N)) begin n_err++;
            $display("FAIL zero_pack: got %h %h expected %h %h", signal_a, signal_b, pack(0), pack(N)); end
`endif
        frame_ack = 1'b1; cyc(); frame_ack = 1'b0; fcnt_exp++;
    endtask

    task automatic test_flush();
        int cyc_n, early; bit tmo;
        logic rdy;
        acc.delete();
        fill_random(19, 1'b1);
        feed(19, 1'b0, 1'b0, cyc_n, early, tmo);
        // The 20th transfer coincides with flush, so the sample must be lost.
        in_valid = 1'b1; in_data = 8'hAA; flush = 1'b1; rdy = in_ready;
        cyc();
        flush = 1'b0; in_valid = 1'b0; acc.delete();
        n_cmp++; if ({rdy, frame_valid, in_ready, zero_a, zero_b} !== 5'b10111) begin n_err++;
            $display("FAIL flush_ctrl: got rdy0/fv/rdy/za/zb=%b expected 10111",
                     {rdy, frame_valid, in_ready, zero_a, zero_b}); end
        fill_random(2*N, 1'b1);
        feed(2*N, 1'b0, 1'b0, cyc_n, early, tmo);
        n_cmp++; if (tmo || cyc_n != 2*N || early != 0 || frame_valid !== 1'b1) begin n_err++;
            $display("FAIL flush_refill: got cycles=%0d early=%0d fv=%b expected 32/0/1", cyc_n, early, frame_valid); end
        n_cmp++; if (signal_a !== pack(0) || signal_b !== pack(N)) begin n_err++;
            $display("FAIL flush_pack: got %h %h expected %h %h", signal_a, signal_b, pack(0), pack(N)); end
        // flush together with ack in HOLD: the frame is not counted.
        frame_ack = 1'b1; flush = 1'b1; cyc(); frame_ack = 1'b0; flush = 1'b0;
        n_cmp++; if (frame_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 16'(fcnt_exp)) begin n_err++;
            $display("FAIL flush_over_ack: got fv=%b rdy=%b fcnt=%0d expected 0/1/%0d",
                     frame_valid, in_ready, frame_cnt, fcnt_exp); end
    endtask

    task automatic test_async_reset();
        int cyc_n, early; bit tmo;
        acc.delete();
        fill_random(20, 1'b1);
        feed(20, 1'b1, 1'b0, cyc_n, early, tmo);
        #3; rst_n = 1'b0; #1;
        fcnt_exp = 0;
        n_cmp++; if ({in_ready, frame_valid, zero_a, zero_b} !== 4'b0011 || signal_a !== '0 || signal_b !== '0
                     || frame_cnt !== 16'd0) begin n_err++;
            $display("FAIL async_reset: got rdy/fv/za/zb=%b a=%h b=%h fcnt=%0d expected 0011 0 0 0",
                     {in_ready, frame_valid, zero_a, zero_b}, signal_a, signal_b, frame_cnt); end
        @(posedge clk); @(posedge clk); #3; rst_n = 1'b1;
        cyc();
        acc.delete();
        fill_random(2*N - 1, 1'b1);
        feed(2*N - 1, 1'b0, 1'b0, cyc_n, early, tmo);
        n_cmp++; if (tmo || early != 0 || frame_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_partial: got fv=%b early=%0d expected 0/0", frame_valid, early); end
        fill_random(1, 1'b1);
        feed(1, 1'b0, 1'b0, cyc_n, early, tmo);
        n_cmp++; if (tmo || frame_valid !== 1'b1 || signal_a !== pack(0) || signal_b !== pack(N)) begin n_err++;
            $display("FAIL reset_refill: got fv=%b %h %h expected 1 %h %h", frame_valid, signal_a, signal_b, pack(0), pack(N)); end
        frame_ack = 1'b1; cyc(); frame_ack = 1'b0; fcnt_exp++;
        n_cmp++; if (frame_cnt !== 16'(fcnt_exp)) begin n_err++;
            $display("FAIL reset_fcnt_after: got %0d expected %0d", frame_cnt, fcnt_exp); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold_ack();
        test_gaps();
        test_zero_frame();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_frame_loader.md
Name: conv_frame_loader

Overview:
- Upstream stage of the 16-tap convolution block.
- Accepts a serial stream of 8-bit samples over a valid/ready handshake and packs the first 16 into signal_a and the next 16 into signal_b.
- Holds the packed frame stable with frame_valid asserted until the convolution side acknowledges it.
- Produces correct per-operand all-zero flags so the downstream invalid-input decision needs no scan of its own.

Parameters:
- N_TAPS, 16, samples per operand; the sample counter is $clog2(N_TAPS) bits wide.
- DATA_W, 8, bits per sample.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  incoming sample.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a sample this cycle.
- flush  input  1  synchronous abort of the current frame.
- frame_ack  input  1  downstream has consumed the presented frame.
- signal_a  output  N_TAPS*DATA_W  operand A; sample k occupies bits [k*DATA_W +: DATA_W].
- signal_b  output  N_TAPS*DATA_W  operand B; same packing as signal_a.
- frame_valid  output  1  signal_a, signal_b, zero_a and zero_b are complete and stable.
- zero_a  output  1  every A sample of the presented frame is 0.
- zero_b  output  1  every B sample of the presented frame is 0.
- frame_cnt  output  16  number of frames acknowledged; wraps at 0xFFFF.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=LOAD_A, sample counter=0.
  - in_ready=0 while rst_n=0; in_ready=1 on the first clock after release.
  - frame_valid=0, signal_a=0, signal_b=0, zero_a=1, zero_b=1, frame_cnt=0.
- Transfer: occurs on a rising edge where in_valid && in_ready. in_ready is a registered function of state: 1 in LOAD_A and LOAD_B, 0 in HOLD.
- LOAD_A:
  - Each transfer writes in_data into slot cnt of signal_a, and zero_a <= zero_a && (in_data==0).
  - After the transfer at cnt=N_TAPS-1: cnt <= 0, state <= LOAD_B.
- LOAD_B:
  - Same as LOAD_A, targeting signal_b and zero_b.
  - After the transfer at cnt=N_TAPS-1: state <= HOLD and frame_valid <= 1, both at the same edge.
  - frame_valid is therefore high in the cycle after the 32nd accepted sample.
- HOLD:
  - in_ready=0; signal_a, signal_b, zero_a and zero_b are frozen.
  - frame_ack=1 at an edge gives: frame_valid <= 0, state <= LOAD_A, cnt <= 0, zero_a <= 1, zero_b <= 1, frame_cnt <= frame_cnt+1.
  - Operand registers keep the old data until they are overwritten.
- frame_ack outside HOLD is ignored, with no effect on any state.
- Minimum frame period is 33 cycles: 32 transfers plus 1 HOLD cycle with immediate ack.
- Back-pressure: in_valid may drop at any point. The counter advances only on transfers, and gaps are permitted inside A and inside B.
- flush=1 at an edge gives: state <= LOAD_A, cnt <= 0, frame_valid <= 0, zero_a <= 1, zero_b <= 1; frame_cnt unchanged.
  - flush has priority over a simultaneous transfer, which is dropped.
  - flush has priority over a simultaneous frame_ack, so frame_cnt does not increment.
- in_data and in_valid are don't-care when no transfer occurs. The loader never samples data without in_ready.
- Reset mid-frame discards the partial frame; loading restarts at sample 0 of A.

Optional Feature:
- Macro: CONV_LOADER_ZERO_DROP_EN.
- When defined:
  - At the edge that would enter HOLD, if zero_a or zero_b (including the final sample) is 1, the frame is discarded instead of presented.
  - frame_valid stays 0; state returns to LOAD_A with cnt=0 and zero flags=1.
  - An added output drop_cnt (16 bits, reset 0, wraps) increments.
  - frame_cnt does not increment for dropped frames.
- When not defined: all-zero frames are presented normally with zero_a/zero_b asserted, and drop_cnt does not exist.

Test Plan:
- Reset, then stream A=1..16 and B=17..32 with in_valid held high:
  - in_ready=0 during reset and 1 from the first cycle after release.
  - Transfers occur on 32 consecutive edges, and frame_valid=1 the cycle after the 32nd.
  - signal_a slot0=0x01, slot15=0x10; signal_b slot0=0x11, slot15=0x20; zero_a=0, zero_b=0.
- Hold frame_ack=0 for 10 cycles while in_valid=1 with new data:
  - in_ready=0 and the operands are unchanged.
  - Pulse frame_ack: frame_valid=0 next cycle, frame_cnt=1, in_ready=1.
- Random in_valid gaps (50% duty) over 32 samples: packed data matches the accepted order and frame_valid rises exactly once.
- A all zero, B=5 in every slot:
  - Without the macro: frame_valid=1, zero_a=1, zero_b=0.
  - With CONV_LOADER_ZERO_DROP_EN: frame_valid never rises, drop_cnt=1, and the next good frame presents normally.
- Assert flush on the same edge as the 20th transfer: the sample is dropped, and the next 32 transfers form a complete fresh frame starting at A slot0.
- Assert rst_n=0 asynchronously mid-LOAD_B (between edges):
  - Outputs take reset values immediately.
  - After release a full 32-sample frame is required before frame_valid.
